aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Parametrised AES round-sequencing controller: sequences the initial AddRoundKey, the full rounds and the final round for AES-128/192/256. It drives the round index and round-type select into the AES datapath. A duplicated next-state function gives fault detection on the state register. It sits between the key-expansion block (key_ready) and the round datapath (data_stable, round_type_sel, round_index).

## Interface
- MAX_ROUNDS, 14: largest round count supported; key lengths needing more rounds are refused.
- RIDX_W, 4: round_index width; must satisfy 2**RIDX_W > MAX_ROUNDS.
- CHECK_EN, 1: 1 = shadow next-state check and illegal-state detection present; 0 = fsm_fault tied 0.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_len  in  2  0 = AES-128 (Nr=10), 1 = AES-192 (Nr=12), 2 = AES-256 (Nr=14), 3 = reserved.
- data_stable  in  1  datapath input block valid; start request.
- key_ready  in  1  round keys available; level, must stay high for the whole operation.
- round_index  out  RIDX_W  current round number, 0..Nr.
- round_type_sel  out  2  0 = init AddRoundKey, 1 = full round, 2 = final round (no MixColumns), 3 = idle/none.
- busy  out  1  high in INIT, ROUND and FINAL.
- finished  out  1  one-cycle pulse, result valid.
- cfg_err  out  1  one-cycle pulse when a start is refused for its configuration.
- fsm_fault  out  1  sticky integrity fault.

## Operation
- States (3-bit binary): IDLE=0, INIT=1, ROUND=2, FINAL=3, DONE=4. Encodings 5–7 are illegal.
- IDLE: start = key_ready & data_stable & !fsm_fault.
  - On start, key_len is latched and Nr is derived.
  - key_len=3, or Nr > MAX_ROUNDS: stay in IDLE, pulse cfg_err.
  - Otherwise go to INIT with round_index=0.
- INIT → ROUND with round_index=1.
- ROUND: increment round_index. When round_index == Nr-1, go to FINAL with round_index=Nr.
- FINAL → DONE. DONE → IDLE, with round_index cleared to 0.
- Abort: key_ready low in INIT/ROUND/FINAL sends the state to IDLE next cycle with round_index=0.
  - No finished pulse is produced.
  - Abort has priority over every other transition, including FINAL→DONE.
- Output decode from the registered state (Moore):
  - round_type_sel = 0/1/2 in INIT/ROUND/FINAL, 3 otherwise.
  - busy = INIT|ROUND|FINAL.
  - finished = (state==DONE).
- Integrity (CHECK_EN=1): a second instance of the next-state function computes a shadow next state and index from the same inputs; both are registered. fsm_fault sets on any of:
  - main/shadow state or index mismatch;
  - illegal state encoding;
  - ROUND with round_index==0 or ≥ Nr;
  - INIT, IDLE or DONE with round_index≠0.
- On fault: the state is forced to IDLE and round_index to 0 on the next edge. fsm_fault holds until rst, and new starts are ignored while it is set.

## Timing
- Reset values: state IDLE, round_index 0, round_type_sel 3, busy 0, finished 0, cfg_err 0, fsm_fault 0, latched Nr 10.
- Start sampled at edge t:
  - INIT in cycle t+1;
  - ROUND in cycles t+2..t+Nr;
  - FINAL in cycle t+Nr+1;
  - finished in cycle t+Nr+2.
- Operation length per Nr: AES-128 finishes 12 cycles after the start edge, AES-192 after 14, AES-256 after 16.
- Back-to-back: DONE always passes through IDLE, so the earliest next start is sampled in the IDLE cycle after DONE.
- data_stable is ignored outside IDLE. key_len changes outside IDLE have no effect.
- cfg_err asserts in the cycle after the refused start sample.
- fsm_fault asserts one cycle after the offending register value appears.
- rst mid-operation returns everything to reset values on that edge; no finished pulse.

## Structure
- Package aes_round_pkg:
  - state enum (IDLE..DONE, 3-bit);
  - round_type_sel constants;
  - key_len constants;
  - function nr_of(key_len) returning 10/12/14.
- Sub-module aes_round_ctrl_next: purely combinational next-state/next-index function with inputs state, round_index, Nr, key_ready, data_stable. It is instantiated twice (main, shadow) when CHECK_EN=1 and once otherwise.
- The top level holds the registers, latched Nr, the output decode and the fault comparator.

## Test plan
- Reset, then key_len=0, key_ready=1, data_stable pulsed → round_index 0,1..9,10 with round_type_sel 0,1×9,2; finished exactly 12 cycles after the start edge; busy high for 11 cycles.
- key_len=2, MAX_ROUNDS=14 → FINAL at round_index=14, finished at +16. Repeat with MAX_ROUNDS=12 → cfg_err pulse, state stays IDLE, busy 0.
- key_len=3 with start → cfg_err one cycle, no busy. Then a legal AES-192 start → finished at +14.
- AES-128 running, key_ready dropped while round_index=5 → next cycle IDLE, round_index 0, round_type_sel 3, no finished. Separately, key_ready dropped in FINAL → no finished.
- Force the main state register to 6 (or corrupt the shadow index) → fsm_fault=1 the next cycle, state IDLE, later starts ignored until rst clears fault.
- data_stable held high continuously with key_ready=1 → consecutive operations separated by exactly one IDLE cycle; finished pulses 13 cycles apart for AES-128.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES round-sequencing controller.
// Holds state encodings, round-type select codes, key-length codes and the Nr lookup.
package aes_round_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_INIT  = 2'd0;
  localparam logic [1:0] SEL_FULL  = 2'd1;
  localparam logic [1:0] SEL_FINAL = 2'd2;
  localparam logic [1:0] SEL_NONE  = 2'd3;

  localparam logic [1:0] KEY_128  = 2'd0;
  localparam logic [1:0] KEY_192  = 2'd1;
  localparam logic [1:0] KEY_256  = 2'd2;
  localparam logic [1:0] KEY_RSVD = 2'd3;

  localparam logic [4:0] NR_RESET = 5'd10;

  // The reserved code maps to 14 here; it is refused separately by the caller.
  function automatic logic [4:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_128: nr_of = 5'd10;
      KEY_192: nr_of = 5'd12;
      default: nr_of = 5'd14;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake bundle between the round controller, key expansion and the round datapath.
interface aes_round_ctrl_if #(
  parameter int RIDX_W = 4
);

  logic [1:0]        key_len;
  logic              data_stable;
  logic              key_ready;
  logic [RIDX_W-1:0] round_index;
  logic [1:0]        round_type_sel;
  logic              busy;
  logic              finished;
  logic              cfg_err;
  logic              fsm_fault;

  modport master (
    output key_len, data_stable, key_ready,
    input  round_index, round_type_sel, busy, finished, cfg_err, fsm_fault
  );

  modport slave (
    input  key_len, data_stable, key_ready,
    output round_index, round_type_sel, busy, finished, cfg_err, fsm_fault
  );

endinterface

// File: rtl/aes_round_ctrl_next.sv
// Combinational next-state / next-round-index function of the round sequencer.
// i_data_stable arrives already qualified by configuration legality and fault status.
module aes_round_ctrl_next
  import aes_round_pkg::*;
#(
  parameter int RIDX_W = 4
) (
  input  logic [2:0]        i_state,
  input  logic [RIDX_W-1:0] i_round_index,
  input  logic [RIDX_W-1:0] i_nr,
  input  logic              i_key_ready,
  input  logic              i_data_stable,
  output logic [2:0]        o_state_next,
  output logic [RIDX_W-1:0] o_round_index_next
);

  localparam logic [RIDX_W-1:0] ONE = RIDX_W'(1);

  // Dropping key_ready anywhere mid-operation falls through to the IDLE default.
  always_comb begin
    o_state_next       = ST_IDLE;
    o_round_index_next = '0;
    case (i_state)
      ST_IDLE: begin
        if (i_key_ready && i_data_stable) begin
          o_state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        if (i_key_ready) begin
          o_state_next       = ST_ROUND;
          o_round_index_next = ONE;
        end
      end
      ST_ROUND: begin
        if (i_key_ready) begin
          if (i_round_index == i_nr - ONE) begin
            o_state_next       = ST_FINAL;
            o_round_index_next = i_nr;
          end else begin
            o_state_next       = ST_ROUND;
            o_round_index_next = i_round_index + ONE;
          end
        end
      end
      ST_FINAL: begin
        if (i_key_ready) begin
          o_state_next = ST_DONE;
        end
      end
      default: begin
        o_state_next       = ST_IDLE;
        o_round_index_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round-sequencing controller: state/index registers, latched Nr, Moore output
// decode and an optional shadow next-state check with sticky integrity fault.
module aes_round_ctrl
  import aes_round_pkg::*;
#(
  parameter int MAX_ROUNDS = 14,
  parameter int RIDX_W     = 4,
  parameter int CHECK_EN   = 1
) (
  input logic             clk,
  input logic             rst,
  aes_round_ctrl_if.slave bus
);

  localparam logic [4:0] MAX_NR = 5'(MAX_ROUNDS);

  logic [2:0]        r_state;
  logic [RIDX_W-1:0] r_round_index;
  logic [RIDX_W-1:0] r_nr;
  logic              r_cfg_err;
  logic              r_fault;

  logic [4:0]        w_nr_req;
  logic              w_cfg_ok;
  logic              w_start_req;
  logic              w_go;
  logic              w_fault_det;
  logic              w_fault_any;
  logic [2:0]        w_state_next;
  logic [RIDX_W-1:0] w_round_index_next;

  assign w_nr_req    = nr_of(bus.key_len);
  assign w_cfg_ok    = (bus.key_len != KEY_RSVD) && (w_nr_req <= MAX_NR);
  assign w_start_req = (r_state == ST_IDLE) && bus.key_ready && bus.data_stable && !r_fault;
  assign w_go        = bus.data_stable && w_cfg_ok && !r_fault;
  assign w_fault_any = w_fault_det || r_fault;

  aes_round_ctrl_next #(.RIDX_W(RIDX_W)) u_next_main (
    .i_state            (r_state),
    .i_round_index      (r_round_index),
    .i_nr               (r_nr),
    .i_key_ready        (bus.key_ready),
    .i_data_stable      (w_go),
    .o_state_next       (w_state_next),
    .o_round_index_next (w_round_index_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_round_index <= '0;
      r_nr          <= RIDX_W'(NR_RESET);
      r_cfg_err     <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_cfg_err <= w_start_req && !w_cfg_ok;
      r_fault   <= w_fault_any;
      if (w_fault_any) begin
        r_state       <= ST_IDLE;
        r_round_index <= '0;
      end else begin
        r_state       <= w_state_next;
        r_round_index <= w_round_index_next;
      end
      if (w_start_req && w_cfg_ok) begin
        r_nr <= RIDX_W'(w_nr_req);
      end
    end
  end

  generate
    if (CHECK_EN != 0) begin : g_check
      logic [2:0]        r_shadow_state;
      logic [RIDX_W-1:0] r_shadow_index;
      logic [2:0]        w_shadow_state_next;
      logic [RIDX_W-1:0] w_shadow_index_next;
      logic              w_idx_bad;

      aes_round_ctrl_next #(.RIDX_W(RIDX_W)) u_next_shadow (
        .i_state            (r_state),
        .i_round_index      (r_round_index),
        .i_nr               (r_nr),
        .i_key_ready        (bus.key_ready),
        .i_data_stable      (w_go),
        .o_state_next       (w_shadow_state_next),
        .o_round_index_next (w_shadow_index_next)
      );

      always_ff @(posedge clk) begin
        if (rst || w_fault_any) begin
          r_shadow_state <= ST_IDLE;
          r_shadow_index <= '0;
        end else begin
          r_shadow_state <= w_shadow_state_next;
          r_shadow_index <= w_shadow_index_next;
        end
      end

      // Round index must be 1..Nr-1 in ROUND and zero in the non-round states.
      always_comb begin
        w_idx_bad = 1'b0;
        case (r_state)
          ST_ROUND: w_idx_bad = (r_round_index == '0) || (r_round_index >= r_nr);
          ST_IDLE, ST_INIT, ST_DONE: w_idx_bad = (r_round_index != '0);
          default: w_idx_bad = 1'b0;
        endcase
      end

      assign w_fault_det = (r_state != r_shadow_state)
                        || (r_round_index != r_shadow_index)
                        || (r_state > ST_DONE)
                        || w_idx_bad;
    end else begin : g_nocheck
      assign w_fault_det = 1'b0;
    end
  endgenerate

  always_comb begin
    bus.round_type_sel = SEL_NONE;
    case (r_state)
      ST_INIT:  bus.round_type_sel = SEL_INIT;
      ST_ROUND: bus.round_type_sel = SEL_FULL;
      ST_FINAL: bus.round_type_sel = SEL_FINAL;
      default:  bus.round_type_sel = SEL_NONE;
    endcase
  end

  assign bus.round_index = r_round_index;
  assign bus.busy        = (r_state == ST_INIT) || (r_state == ST_ROUND) || (r_state == ST_FINAL);
  assign bus.finished    = (r_state == ST_DONE);
  assign bus.cfg_err     = r_cfg_err;
  assign bus.fsm_fault   = r_fault;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a cycle-level reference model, counted in cycles since
// the start edge, queues expected outputs and a monitor compares them on falling edges.
module tb_aes_round_ctrl;
  import aes_round_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if #(.RIDX_W(4)) bus ();
  aes_round_ctrl_if #(.RIDX_W(4)) bus12 ();

  aes_round_ctrl #(.MAX_ROUNDS(14), .RIDX_W(4), .CHECK_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  aes_round_ctrl #(.MAX_ROUNDS(12), .RIDX_W(4), .CHECK_EN(1)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  typedef struct {
    int idx;
    int sel;
    bit busy;
    bit fin;
    bit cfg;
    bit fault;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   inject = 1'b0;

  // Reference model state: operation active, cycle number since start edge, Nr.
  bit m_active = 1'b0;
  bit m_fault  = 1'b0;
  bit m_cfg    = 1'b0;
  int m_ph     = 0;
  int m_nr     = 10;
  int m_n;
  exp_t m_e;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0;
        m_fault  = 1'b0;
        m_cfg    = 1'b0;
      end else begin
        m_cfg = 1'b0;
        if (inject) begin
          m_fault  = 1'b1;
          m_active = 1'b0;
          inject   = 1'b0;
        end else if (m_active) begin
          if (m_ph <= m_nr + 1 && !bus.key_ready) m_active = 1'b0;
          else if (m_ph == m_nr + 2)              m_active = 1'b0;
          else                                    m_ph++;
        end else if (bus.key_ready && bus.data_stable && !m_fault) begin
          m_n = (bus.key_len == 2'd0) ? 10 : (bus.key_len == 2'd1) ? 12 : 14;
          if (bus.key_len == 2'd3 || m_n > 14) begin
            m_cfg = 1'b1;
          end else begin
            m_active = 1'b1;
            m_ph     = 1;
            m_nr     = m_n;
          end
        end
      end
      m_e.idx  = 0;
      m_e.sel  = 3;
      m_e.busy = 1'b0;
      m_e.fin  = 1'b0;
      if (m_active) begin
        if (m_ph == 1) begin
          m_e.sel  = 0;
          m_e.busy = 1'b1;
        end else if (m_ph <= m_nr) begin
          m_e.sel  = 1;
          m_e.idx  = m_ph - 1;
          m_e.busy = 1'b1;
        end else if (m_ph == m_nr + 1) begin
          m_e.sel  = 2;
          m_e.idx  = m_nr;
          m_e.busy = 1'b1;
        end else begin
          m_e.fin = 1'b1;
        end
      end
      m_e.cfg   = m_cfg;
      m_e.fault = m_fault;
      q.push_back(m_e);
    end
  end

  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        if (int'(bus.round_index) != mon_e.idx || int'(bus.round_type_sel) != mon_e.sel ||
            bus.busy != mon_e.busy || bus.finished != mon_e.fin ||
            bus.cfg_err != mon_e.cfg || bus.fsm_fault != mon_e.fault) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got idx=%0d sel=%0d busy=%0b fin=%0b cfg=%0b fault=%0b exp idx=%0d sel=%0d busy=%0b fin=%0b cfg=%0b fault=%0b",
                   $time, bus.round_index, bus.round_type_sel, bus.busy, bus.finished,
                   bus.cfg_err, bus.fsm_fault, mon_e.idx, mon_e.sel, mon_e.busy,
                   mon_e.fin, mon_e.cfg, mon_e.fault);
        end else if (mon_e.fin) begin
          $display("txn finished t=%0t", $time);
        end else if (mon_e.cfg) begin
          $display("txn cfg_err t=%0t", $time);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] kl);
    bus.key_len     = kl;
    bus.data_stable = 1'b1;
    step(1);
    bus.data_stable = 1'b0;
  endtask

  task automatic check12(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end else begin
      $display("txn %s value=%0d", name, got);
    end
  endtask

  int fin_at;
  int busy_cnt;

  initial begin
    rst               = 1'b1;
    bus.key_len       = 2'd0;
    bus.data_stable   = 1'b0;
    bus.key_ready     = 1'b0;
    bus12.key_len     = 2'd0;
    bus12.data_stable = 1'b0;
    bus12.key_ready   = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    bus.key_ready = 1'b1;
    pulse_start(2'd0); step(15);
    pulse_start(2'd2); step(18);
    pulse_start(2'd3); step(3);
    pulse_start(2'd1); step(16);

    // Abort while round_index is 5.
    pulse_start(2'd0); step(5);
    bus.key_ready = 1'b0; step(1);
    bus.key_ready = 1'b1; step(3);

    // Abort in FINAL.
    pulse_start(2'd0); step(10);
    bus.key_ready = 1'b0; step(1);
    bus.key_ready = 1'b1; step(3);

    // Continuous start requests.
    bus.key_len     = 2'd0;
    bus.data_stable = 1'b1;
    step(45);
    bus.data_stable = 1'b0;
    step(15);

    for (int i = 0; i < 400; i++) begin
      bus.key_len     = 2'($urandom_range(0, 3));
      bus.data_stable = ($urandom_range(0, 3) == 0);
      bus.key_ready   = ($urandom_range(0, 49) != 0);
      step(1);
    end
    bus.key_ready   = 1'b1;
    bus.data_stable = 1'b0;
    step(18);

    // Corrupt the main state register to an illegal encoding.
    #2;
    force dut.r_state = 3'd6;
    inject = 1'b1;
    @(negedge clk);
    #2;
    release dut.r_state;
    bus.key_len     = 2'd0;
    bus.data_stable = 1'b1;
    step(6);
    bus.data_stable = 1'b0;
    step(2);
    rst = 1'b1; step(1);
    rst = 1'b0; step(1);
    pulse_start(2'd0); step(15);

    // Reset in the middle of an operation.
    pulse_start(2'd2); step(7);
    rst = 1'b1; step(1);
    rst = 1'b0; step(2);
    pulse_start(2'd0); step(15);

    // Instance limited to 12 rounds refuses AES-256 but runs AES-192.
    bus12.key_ready   = 1'b1;
    bus12.key_len     = 2'd2;
    bus12.data_stable = 1'b1;
    step(1);
    bus12.data_stable = 1'b0;
    check12("max12_cfg_err", int'(bus12.cfg_err), 1);
    check12("max12_busy_refused", int'(bus12.busy), 0);
    step(1);
    check12("max12_cfg_err_pulse", int'(bus12.cfg_err), 0);
    check12("max12_sel_idle", int'(bus12.round_type_sel), 3);
    bus12.key_len     = 2'd1;
    bus12.data_stable = 1'b1;
    step(1);
    bus12.data_stable = 1'b0;
    fin_at   = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus12.finished && fin_at < 0) fin_at = k;
      if (bus12.busy) busy_cnt++;
      step(1);
    end
    check12("max12_aes192_finish_cycle", fin_at, 14);
    check12("max12_aes192_busy_cycles", busy_cnt, 13);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
